exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/exec_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction execution sequencer: state
// encoding, recognised opcodes and the RAM wait timeout.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_REC   = 3'd4
    } state_t;

    localparam logic [6:0] RALU   = 7'b0110011;
    localparam logic [6:0] IALU   = 7'b0010011;
    localparam logic [6:0] ILOAD  = 7'b0000011;
    localparam logic [6:0] SSTORE = 7'b0100011;

    // Last wait count before a RAM access is abandoned.
    localparam logic [3:0] TIMEOUT = 4'd15;

    // Register-to-register or immediate ALU instruction.
    function automatic logic is_alu(input logic [6:0] op);
        return (op == RALU) || (op == IALU);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// RAM wait counter: cleared before each access, counts MEM cycles in which
// the RAM has not answered, flags the timeout value.
module mem_wait_timer
    import ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] count,
    output logic       expired
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear wins over enable; no saturation is needed because
    // the sequencer leaves MEM when the timeout value is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (enable) begin
            count_d = count_q + 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == TIMEOUT);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> (MEM -> WB/REC) -> FETCH.
// Optional feature macro: STORE_SEQ_EN (store instructions go through MEM
// with ram_we=1); when undefined a store is a single-cycle no-op.
module exec_sequencer
    import ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic       pc_en,
    output logic       regw_en,
    output logic       ram_req,
    output logic       ram_we,
    output logic       busy,
    output logic       illegal,
    output logic       mem_err
);

    state_t     state_q;
    state_t     state_d;
    logic       we_q;
    logic [3:0] wait_count;
    logic       wait_expired;

    logic ir_load_c, pc_en_c, regw_en_c, ram_req_c, illegal_c, mem_err_c, busy_c;

`ifdef STORE_SEQ_EN
    logic we_d;

    // Access direction is latched in EXEC and held through MEM.
    always_comb begin
        we_d = we_q;
        if (state_q == S_EXEC) begin
            we_d = (opcode == SSTORE);
        end
    end

    // Direction register.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q <= 1'b0;
        end else begin
            we_q <= we_d;
        end
    end
`else
    assign we_q = 1'b0;
`endif

    mem_wait_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == S_EXEC),
        .enable  ((state_q == S_MEM) && !mem_ready && !wait_expired),
        .count   (wait_count),
        .expired (wait_expired)
    );

    // Next-state and strobe decode from current state, opcode and (in MEM only) mem_ready.
    always_comb begin
        state_d   = state_q;
        ir_load_c = 1'b0;
        pc_en_c   = 1'b0;
        regw_en_c = 1'b0;
        ram_req_c = 1'b0;
        illegal_c = 1'b0;
        mem_err_c = 1'b0;
        busy_c    = (state_q != S_FETCH);
        case (state_q)
            S_FETCH: begin
                ir_load_c = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu(opcode)) begin
                    regw_en_c = 1'b1;
                    pc_en_c   = 1'b1;
                    state_d   = S_FETCH;
                end else if (opcode == ILOAD) begin
                    ram_req_c = 1'b1;
                    state_d   = S_MEM;
                end else if (opcode == SSTORE) begin
`ifdef STORE_SEQ_EN
                    ram_req_c = 1'b1;
                    state_d   = S_MEM;
`else
                    pc_en_c   = 1'b1;
                    state_d   = S_FETCH;
`endif
                end else begin
                    illegal_c = 1'b1;
                    pc_en_c   = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM: begin
                ram_req_c = 1'b1;
                if (mem_ready) begin
                    // A late acceptance on the timeout cycle still succeeds.
                    if (we_q) begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    ram_req_c = 1'b0;
                    mem_err_c = 1'b1;
                    state_d   = S_REC;
                end
            end
            S_WB: begin
                regw_en_c = 1'b1;
                pc_en_c   = 1'b1;
                state_d   = S_FETCH;
            end
            S_REC: begin
                pc_en_c = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register; reset overrides any in-flight transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // All strobes are held quiet while reset is asserted.
    assign ir_load = ir_load_c & ~reset;
    assign pc_en   = pc_en_c   & ~reset;
    assign regw_en = regw_en_c & ~reset;
    assign ram_req = ram_req_c & ~reset;
    assign ram_we  = ram_req_c & we_q & ~reset;
    assign busy    = busy_c    & ~reset;
    assign illegal = illegal_c & ~reset;
    assign mem_err = mem_err_c & ~reset;

    // The count value itself is only observed through the expired flag.
    logic unused_count;
    assign unused_count = ^wait_count;

endmodule
